// File: rtl/csi2_px_pkg.sv
// Shared RAW10 pixel and beat types for the CSI-2 pixel-domain unpacker.
// A beat is four packed 10-bit pixels, pixel k in bits [10k+9:10k].
package csi2_px_pkg;

    localparam int RAW10_PX_W        = 10;
    localparam int RAW10_PX_PER_BEAT = 4;

    typedef logic [RAW10_PX_W-1:0] raw10_px_t;
    typedef raw10_px_t [RAW10_PX_PER_BEAT-1:0] raw10_beat_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } unpk_state_e;

endpackage

// File: rtl/csi2_line_len_checker.sv
// Counts emitted pixels per line and flags lines whose length differs from FRAME_WIDTH.
// Latency: line_err_o pulses one cycle after the tlast handshake.
// Backpressure: passive observer, only counts completed output handshakes.
module csi2_line_len_checker
    import csi2_px_pkg::*;
#(
    parameter int PX_PER_CLK  = 1,
    parameter int FRAME_WIDTH = 1920
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic px_hs_i,
    input  logic sof_i,
    input  logic eol_i,
    output logic line_err_o
);

    logic [15:0] px_cnt;
    logic [16:0] cnt_base;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_next;

    // A start-of-frame beat restarts counting with its own pixels.
    always_comb begin
        cnt_base = sof_i ? 17'd0 : {1'b0, px_cnt};
        cnt_sum  = cnt_base + 17'(PX_PER_CLK);
        cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            px_cnt     <= '0;
            line_err_o <= 1'b0;
        end else begin
            line_err_o <= 1'b0;
            if (px_hs_i) begin
                if (eol_i) begin
                    px_cnt     <= '0;
                    line_err_o <= (cnt_next != 16'(FRAME_WIDTH));
                end else begin
                    px_cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: rtl/csi2_raw10_px_unpacker.sv
// Unpacks 40-bit RAW10 beats into a PX_PER_CLK-pixel video stream (tuser=SOF, tlast=EOL); CSI2_LINE_CHECK_EN adds line-length checking.
// Latency: first output pixel valid one cycle after the input beat is accepted.
// Backpressure: one-beat skid buffer; s_tready_o rises only when the final slot drains or the buffer is empty.
module csi2_raw10_px_unpacker
    import csi2_px_pkg::*;
#(
    parameter int PX_PER_CLK  = 1,
    parameter int FRAME_WIDTH = 1920
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             frame_start_i,
    input  logic [39:0]                      s_tdata_i,
    input  logic                             s_tvalid_i,
    input  logic                             s_tlast_i,
    output logic                             s_tready_o,
    output logic [RAW10_PX_W*PX_PER_CLK-1:0] m_tdata_o,
    output logic                             m_tvalid_o,
    output logic                             m_tuser_o,
    output logic                             m_tlast_o,
    input  logic                             m_tready_i,
    output logic                             line_err_o
);

    localparam int         SLOTS    = RAW10_PX_PER_BEAT / PX_PER_CLK;
    localparam logic [1:0] LAST_IDX = 2'(SLOTS - 1);
    localparam int         OUT_W    = RAW10_PX_W * PX_PER_CLK;

    if (!(PX_PER_CLK == 1 || PX_PER_CLK == 2 || PX_PER_CLK == 4)) begin : g_bad_px_per_clk
        $error("csi2_raw10_px_unpacker: PX_PER_CLK must be 1, 2 or 4");
    end
    if (FRAME_WIDTH < 1 || FRAME_WIDTH > 65535) begin : g_bad_frame_width
        $error("csi2_raw10_px_unpacker: FRAME_WIDTH must fit the 16-bit pixel counter");
    end

    unpk_state_e state_q, state_d;
    raw10_beat_t buf_dat;
    logic [39:0] buf_flat;
    logic        buf_sof;
    logic        buf_last;
    logic [1:0]  idx;
    logic        sof_pending;
    logic        final_take;
    logic        accept;

    always_comb begin
        state_d    = state_q;
        final_take = (state_q == HOLD) && m_tready_i && (idx == LAST_IDX);
        s_tready_o = (state_q == EMPTY) || final_take;
        accept     = s_tvalid_i && s_tready_o;
        m_tvalid_o = (state_q == HOLD);
        case (state_q)
            EMPTY:   if (accept) state_d = HOLD;
            HOLD:    if (final_take && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    // A frame start coinciding with acceptance tags that same beat.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            buf_dat     <= '0;
            buf_sof     <= 1'b0;
            buf_last    <= 1'b0;
            idx         <= 2'd0;
            sof_pending <= 1'b0;
        end else if (accept) begin
            buf_dat     <= s_tdata_i;
            buf_sof     <= sof_pending || frame_start_i;
            buf_last    <= s_tlast_i;
            idx         <= 2'd0;
            sof_pending <= 1'b0;
        end else begin
            if (frame_start_i) sof_pending <= 1'b1;
            if (final_take) begin
                idx <= 2'd0;
            end else if (m_tvalid_o && m_tready_i) begin
                idx <= idx + 2'd1;
            end
        end
    end

    assign buf_flat  = buf_dat;
    assign m_tdata_o = OUT_W'(buf_flat >> (OUT_W * int'(idx)));
    assign m_tuser_o = m_tvalid_o && buf_sof && (idx == 2'd0);
    assign m_tlast_o = m_tvalid_o && buf_last && (idx == LAST_IDX);

`ifdef CSI2_LINE_CHECK_EN
    csi2_line_len_checker #(
        .PX_PER_CLK  (PX_PER_CLK),
        .FRAME_WIDTH (FRAME_WIDTH)
    ) u_line_len_checker (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .px_hs_i    (m_tvalid_o && m_tready_i),
        .sof_i      (m_tuser_o),
        .eol_i      (m_tlast_o),
        .line_err_o (line_err_o)
    );
`else
    assign line_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_raw10_px_unpacker.sv
// Bench for csi2_raw10_px_unpacker: three instances (PX_PER_CLK 1, 2, 4, FRAME_WIDTH 8)
// checked against a pixel-queue model of the RAW10 stream.
module tb_csi2_raw10_px_unpacker;

    localparam int N = 8192;
`ifdef CSI2_LINE_CHECK_EN
    localparam bit LINE_CHK = 1'b1;
`else
    localparam bit LINE_CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        frame_start [3];
    logic [39:0] s_tdata     [3];
    logic        s_tvalid    [3];
    logic        s_tlast     [3];
    logic        s_tready    [3];
    logic [39:0] m_tdata     [3];
    logic        m_tvalid    [3];
    logic        m_tuser     [3];
    logic        m_tlast     [3];
    logic        m_tready    [3];
    logic        line_err    [3];

    // expected pixel stream per instance, with SOF/EOL flags per pixel
    logic [9:0] ex_px  [3][N];
    bit         ex_sof [3][N];
    bit         ex_eol [3][N];
    int         wp [3];
    int         rp [3];
    bit         pend [3];
    int         lcnt [3];
    bit         err_due [3];
    bit         mon_en [3];
    int         rdy_pct [3];
    int         stall_cnt [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int PX = 1 << g;
        logic [10*PX-1:0] mt;
        logic [39:0]      p_dat;
        logic [39:0]      ed;
        bit               p_usr, p_lst, p_stall, eu, el;

        csi2_raw10_px_unpacker #(.PX_PER_CLK(PX), .FRAME_WIDTH(8)) u_dut (
            .clk_i         (clk),
            .rst_n_i       (rst_n),
            .frame_start_i (frame_start[g]),
            .s_tdata_i     (s_tdata[g]),
            .s_tvalid_i    (s_tvalid[g]),
            .s_tlast_i     (s_tlast[g]),
            .s_tready_o    (s_tready[g]),
            .m_tdata_o     (mt),
            .m_tvalid_o    (m_tvalid[g]),
            .m_tuser_o     (m_tuser[g]),
            .m_tlast_o     (m_tlast[g]),
            .m_tready_i    (m_tready[g]),
            .line_err_o    (line_err[g])
        );
        assign m_tdata[g] = 40'(mt);

        always @(negedge clk) m_tready[g] = ($urandom_range(99) < rdy_pct[g]);

        always @(negedge clk) begin
            #2;
            if (!mon_en[g]) begin
                p_stall = 0;
            end else begin
                chk($sformatf("g%0d_line_err", g), 40'(line_err[g]), 40'(err_due[g]));
                err_due[g] = 0;
                if (p_stall) begin
                    chk($sformatf("g%0d_stall_valid", g), 40'(m_tvalid[g]), 40'd1);
                    chk($sformatf("g%0d_stall_data", g), m_tdata[g], p_dat);
                    chk($sformatf("g%0d_stall_user", g), 40'(m_tuser[g]), 40'(p_usr));
                    chk($sformatf("g%0d_stall_last", g), 40'(m_tlast[g]), 40'(p_lst));
                end
                if (m_tvalid[g] && m_tready[g]) begin
                    if (wp[g] - rp[g] < PX) begin
                        chk($sformatf("g%0d_unexpected_beat", g), 40'd1, 40'd0);
                    end else begin
                        ed = '0;
                        for (int j = 0; j < PX; j++) ed[10*j +: 10] = ex_px[g][(rp[g] + j) % N];
                        eu = ex_sof[g][rp[g] % N];
                        el = ex_eol[g][(rp[g] + PX - 1) % N];
                        chk($sformatf("g%0d_data", g), m_tdata[g], ed);
                        chk($sformatf("g%0d_tuser", g), 40'(m_tuser[g]), 40'(eu));
                        chk($sformatf("g%0d_tlast", g), 40'(m_tlast[g]), 40'(el));
                        rp[g] += PX;
                        lcnt[g] = eu ? PX : lcnt[g] + PX;
                        if (el) begin
                            err_due[g] = LINE_CHK && (lcnt[g] != 8);
                            lcnt[g] = 0;
                        end
                    end
                end
                p_stall = m_tvalid[g] && !m_tready[g];
                p_dat   = m_tdata[g];
                p_usr   = m_tuser[g];
                p_lst   = m_tlast[g];
            end
        end
    end

    task automatic idle(input int g, input bit fs);
        @(negedge clk);
        s_tvalid[g] = 0;
        s_tlast[g] = 0;
        frame_start[g] = fs;
        #2;
        if (fs) pend[g] = 1;
    endtask

    task automatic put_beat(input int g, input logic [39:0] d, input bit last, input bit fs);
        bit done;
        bit sof;
        done = 0;
        @(negedge clk);
        s_tdata[g] = d;
        s_tlast[g] = last;
        s_tvalid[g] = 1;
        frame_start[g] = fs;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                frame_start[g] = 0;
                stall_cnt[g]++;
            end
            #2;
            if (s_tready[g]) begin
                done = 1;
                sof = pend[g] || frame_start[g];
                pend[g] = 0;
                for (int k = 0; k < 4; k++) begin
                    ex_px[g][(wp[g] + k) % N]  = d[10*k +: 10];
                    ex_sof[g][(wp[g] + k) % N] = (k == 0) && sof;
                    ex_eol[g][(wp[g] + k) % N] = (k == 3) && last;
                end
                wp[g] += 4;
            end else if (frame_start[g]) begin
                pend[g] = 1;
            end
        end
        if (!done) chk($sformatf("g%0d_accept_timeout", g), 40'd0, 40'd1);
    endtask

    task automatic stream(input int g, input int nbeats, input int line_beats, input int lpf,
                          input int gap_pct, input int early_pct);
        bit          first;
        bit          fs_now;
        logic [39:0] d;
        for (int b = 0; b < nbeats; b++) begin
            first  = (b % (line_beats * lpf)) == 0;
            fs_now = 0;
            d      = {8'($urandom()), $urandom()};
            if (first && $urandom_range(99) < early_pct) begin
                idle(g, 1);
                idle(g, 1'($urandom_range(1)));
            end else if (first) begin
                fs_now = 1;
            end else if ($urandom_range(99) < gap_pct) begin
                idle(g, 0);
            end
            put_beat(g, d, ((b + 1) % line_beats) == 0, fs_now);
        end
        idle(g, 0);
    endtask

    task automatic chk_rst(input int g, input string pfx);
        chk($sformatf("%s_g%0d_tvalid", pfx, g), 40'(m_tvalid[g]), 40'd0);
        chk($sformatf("%s_g%0d_tuser", pfx, g), 40'(m_tuser[g]), 40'd0);
        chk($sformatf("%s_g%0d_tlast", pfx, g), 40'(m_tlast[g]), 40'd0);
        chk($sformatf("%s_g%0d_s_tready", pfx, g), 40'(s_tready[g]), 40'd1);
        chk($sformatf("%s_g%0d_line_err", pfx, g), 40'(line_err[g]), 40'd0);
        chk($sformatf("%s_g%0d_tdata", pfx, g), m_tdata[g], 40'd0);
    endtask

    task automatic flush_model();
        for (int g = 0; g < 3; g++) begin
            rp[g] = wp[g];
            pend[g] = 0;
            lcnt[g] = 0;
            err_due[g] = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0]  pat [4];
        logic [39:0] d;
        pat = '{10'h001, 10'h100, 10'h200, 10'h3FF};
        for (int g = 0; g < 3; g++) begin
            frame_start[g] = 0; s_tvalid[g] = 0; s_tlast[g] = 0; s_tdata[g] = '0;
            mon_en[g] = 0; rdy_pct[g] = 100; wp[g] = 0; rp[g] = 0;
            pend[g] = 0; lcnt[g] = 0; err_due[g] = 0; stall_cnt[g] = 0;
        end
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #2;
        for (int g = 0; g < 3; g++) chk_rst(g, "reset");

        // single beat, PX_PER_CLK=1, downstream always ready
        put_beat(0, {10'h3FF, 10'h200, 10'h100, 10'h001}, 1, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            s_tvalid[0] = 0;
            #2;
            chk($sformatf("px1_valid_%0d", c), 40'(m_tvalid[0]), 40'd1);
            chk($sformatf("px1_data_%0d", c), m_tdata[0], 40'(pat[c]));
            chk($sformatf("px1_tlast_%0d", c), 40'(m_tlast[0]), 40'(c == 3));
            chk($sformatf("px1_tuser_%0d", c), 40'(m_tuser[0]), 40'd0);
            chk($sformatf("px1_s_tready_%0d", c), 40'(s_tready[0]), 40'(c == 3));
        end
        @(negedge clk);
        #2;
        chk("px1_drained_valid", 40'(m_tvalid[0]), 40'd0);
        chk("px1_short_line_err", 40'(line_err[0]), 40'(LINE_CHK));
        flush_model();

        // random traffic; instance 2 runs one 480-beat line back to back
        for (int g = 0; g < 3; g++) mon_en[g] = 1;
        rdy_pct[0] = 70; rdy_pct[1] = 50; rdy_pct[2] = 100;
        fork
            stream(0, 48, 2, 3, 30, 50);
            stream(1, 60, 3, 2, 20, 50);
            begin
                stream(2, 480, 480, 1, 0, 0);
                chk("px4_b2b_stalls", 40'(stall_cnt[2]), 40'd0);
            end
        join
        repeat (60) @(negedge clk);
        #2;
        for (int g = 0; g < 3; g++) chk($sformatf("g%0d_drained_1", g), 40'(wp[g] - rp[g]), 40'd0);

        // reset while slot 2 of a PX_PER_CLK=1 beat is on the output
        for (int g = 0; g < 3; g++) mon_en[g] = 0;
        rdy_pct[0] = 100;
        repeat (2) @(negedge clk);
        d = {8'($urandom()), $urandom()};
        put_beat(0, d, 1, 0);
        @(negedge clk);
        s_tvalid[0] = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_mid_px2_data", m_tdata[0], 40'(d[29:20]));
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        #2;
        chk_rst(0, "mid_rst");
        flush_model();
        for (int g = 0; g < 3; g++) mon_en[g] = 1;
        repeat (6) @(negedge clk);
        #2;
        chk("post_rst_idle_valid", 40'(m_tvalid[0]), 40'd0);

        rdy_pct[0] = 50; rdy_pct[1] = 50; rdy_pct[2] = 60;
        fork
            stream(0, 40, 2, 2, 10, 50);
            stream(1, 40, 2, 2, 10, 50);
            stream(2, 60, 3, 2, 20, 50);
        join
        repeat (60) @(negedge clk);
        #2;
        for (int g = 0; g < 3; g++) chk($sformatf("g%0d_drained_2", g), 40'(wp[g] - rp[g]), 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
